// File: rtl/kyber_pkg.sv
// Shared Kyber ring constants and the coefficient type used by the polynomial
// arithmetic blocks.
package kyber_pkg;

    localparam int KYBER_DATA_WID = 12;
    localparam int KYBER_Q        = 3329;
    localparam int KYBER_N_COEFF  = 256;

    typedef logic [KYBER_DATA_WID-1:0] coeff_t;

    function automatic int beats_per_poly(input int n_coeff, input int lanes);
        return n_coeff / lanes;
    endfunction

endpackage

// File: rtl/mod_add_lane.sv
// One lane of modular add/subtract: the unreduced first-stage sum and the
// single conditional subtraction applied to the registered sum.
module mod_add_lane
    import kyber_pkg::*;
#(
    parameter int DATA_WID = KYBER_DATA_WID,
    parameter int Q        = KYBER_Q
) (
    input  logic [DATA_WID-1:0] a,
    input  logic [DATA_WID-1:0] b,
    input  logic                mode_sub,
    output logic [DATA_WID:0]   raw,
    input  logic [DATA_WID:0]   raw_reg,
    output logic [DATA_WID-1:0] result
);

    localparam logic [DATA_WID:0] Q_EXT = (DATA_WID+1)'(Q);

    // Adding Q before subtracting b keeps the intermediate non-negative for
    // in-range operands, so one conditional subtraction fully reduces it.
    function automatic logic [DATA_WID:0] raw_sum(
        input logic [DATA_WID-1:0] x,
        input logic [DATA_WID-1:0] y,
        input logic                sub
    );
        if (sub) begin
            return {1'b0, x} + Q_EXT - {1'b0, y};
        end
        return {1'b0, x} + {1'b0, y};
    endfunction

    function automatic logic [DATA_WID-1:0] reduce_once(input logic [DATA_WID:0] r);
        logic signed [DATA_WID+1:0] diff;
        diff = $signed({1'b0, r}) - $signed({1'b0, Q_EXT});
        return diff[DATA_WID+1] ? DATA_WID'(r) : DATA_WID'(diff);
    endfunction

    always_comb begin
        raw    = raw_sum(a, b, mode_sub);
        result = reduce_once(raw_reg);
    end

endmodule

// File: rtl/poly_mod_add_pipe.sv
// Two-stage pipelined coefficient-wise add/subtract mod Q over LANES lanes,
// with valid/ready flow control, per-polynomial last marker and range flag.
module poly_mod_add_pipe
    import kyber_pkg::*;
#(
    parameter int DATA_WID = KYBER_DATA_WID,
    parameter int Q        = KYBER_Q,
    parameter int LANES    = 4,
    parameter int N_COEFF  = KYBER_N_COEFF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      mode_sub,
    input  logic [LANES*DATA_WID-1:0] in_a,
    input  logic [LANES*DATA_WID-1:0] in_b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*DATA_WID-1:0] out_sum,
    output logic                      out_last,
    output logic                      range_err
);

    localparam int BEATS = beats_per_poly(N_COEFF, LANES);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);
    localparam logic [DATA_WID-1:0] Q_C = DATA_WID'(Q);
    localparam int RAW_W = DATA_WID + 1;

    logic                      en;
    logic                      vld_p1;
    logic                      vld_p2;
    logic [LANES*RAW_W-1:0]    raw_c;
    logic [LANES*RAW_W-1:0]    raw_p1;
    logic [LANES*DATA_WID-1:0] res_c;
    logic [LANES*DATA_WID-1:0] sum_p2;
    logic [CNT_W-1:0]          beat_cnt;
    logic                      err_q;
    logic                      bad_beat;

    function automatic logic any_out_of_range(
        input logic [LANES*DATA_WID-1:0] va,
        input logic [LANES*DATA_WID-1:0] vb
    );
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (va[i*DATA_WID +: DATA_WID] >= Q_C || vb[i*DATA_WID +: DATA_WID] >= Q_C) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mod_add_lane #(
            .DATA_WID (DATA_WID),
            .Q        (Q)
        ) u_lane (
            .a        (in_a[i*DATA_WID +: DATA_WID]),
            .b        (in_b[i*DATA_WID +: DATA_WID]),
            .mode_sub (mode_sub),
            .raw      (raw_c[i*RAW_W +: RAW_W]),
            .raw_reg  (raw_p1[i*RAW_W +: RAW_W]),
            .result   (res_c[i*DATA_WID +: DATA_WID])
        );
    end

    // A stalled output freezes the whole pipe; ready depends only on state
    // and out_ready, never on in_valid.
    always_comb begin
        en       = !vld_p2 || out_ready;
        in_ready = en;
        bad_beat = any_out_of_range(in_a, in_b);
    end

    // Stage p1: unreduced sums; bubbles overwrite whatever was held
    always_ff @(posedge clk) begin
        if (en) begin
            raw_p1 <= raw_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (en) begin
            vld_p1 <= in_valid;
        end
    end

    // Stage p2: reduced results presented downstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2 <= 1'b0;
            sum_p2 <= '0;
        end else if (en) begin
            vld_p2 <= vld_p1;
            sum_p2 <= res_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (vld_p2 && out_ready) begin
            beat_cnt <= (beat_cnt == LAST_CNT) ? '0 : beat_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (in_valid && en && bad_beat) begin
            err_q <= 1'b1;
        end
    end

    assign out_valid = vld_p2;
    assign out_sum   = sum_p2;
    assign out_last  = vld_p2 && (beat_cnt == LAST_CNT);
    assign range_err = err_q;

endmodule
